// File: rtl/cpu_pkg.sv
// Shared definitions for the multi-cycle execution unit: opcodes, instruction
// field positions and the sequencing state encoding.
package cpu_pkg;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_MOV  = 4'h1;
    localparam logic [3:0] OP_ADD  = 4'h2;
    localparam logic [3:0] OP_SUB  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_NOT  = 4'h7;
    localparam logic [3:0] OP_INC  = 4'h8;
    localparam logic [3:0] OP_DEC  = 4'h9;
    localparam logic [3:0] OP_SHL  = 4'hA;
    localparam logic [3:0] OP_SHR  = 4'hB;
    localparam logic [3:0] OP_LD   = 4'hC;
    localparam logic [3:0] OP_ST   = 4'hD;
    localparam logic [3:0] OP_JMP  = 4'hE;
    localparam logic [3:0] OP_HALT = 4'hF;

    localparam int OP_LSB = 12;
    localparam int W_LSB  = 6;
    localparam int R_LSB  = 3;
    localparam int S_LSB  = 0;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_MEM,
        ST_HALT
    } state_t;

    // Only the arithmetic, logic and shift group touches {C,N,Z}.
    function automatic logic sets_flags(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_SHR);
    endfunction

endpackage

// File: rtl/alu_cnz.sv
// Combinational ALU for the execution unit: result plus carry/borrow, negative
// and zero indications.
module alu_cnz
    import cpu_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic [3:0]    op,
    input  logic [DW-1:0] r,
    input  logic [DW-1:0] s,
    output logic [DW-1:0] result,
    output logic          c,
    output logic          n,
    output logic          z
);

    always_comb begin
        result = '0;
        c      = 1'b0;
        case (op)
            OP_MOV: result = s;
            OP_ADD: {c, result} = {1'b0, r} + {1'b0, s};
            OP_SUB: begin
                result = r - s;
                c      = (r < s);
            end
            OP_AND: result = r & s;
            OP_OR:  result = r | s;
            OP_XOR: result = r ^ s;
            OP_NOT: result = ~s;
            OP_INC: {c, result} = {1'b0, s} + (DW+1)'(1);
            OP_DEC: begin
                result = s - DW'(1);
                c      = (s == '0);
            end
            OP_SHL: begin
                result = {s[DW-2:0], 1'b0};
                c      = s[DW-1];
            end
            OP_SHR: begin
                result = {1'b0, s[DW-1:1]};
                c      = s[0];
            end
            default: result = '0;
        endcase
        n = result[DW-1];
        z = (result == '0);
    end

endmodule

// File: rtl/cpu_eu_mc.sv
// Multi-cycle execution unit: FETCH/DECODE/EXEC/MEM/HALT sequencer with an
// 8-entry register file and a req/ack memory port that tolerates wait states.
module cpu_eu_mc
    import cpu_pkg::*;
#(
    parameter int            DW     = 16,
    parameter int            AW     = 16,
    parameter logic [AW-1:0] RST_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic [AW-1:0] pc_out,
    output logic [2:0]    flags,
    output logic          halted
);

    state_t        state_q, state_d;
    logic [AW-1:0] pc_q, pc_d;
    logic [15:0]   ir_q, ir_d;
    logic [DW-1:0] regs_q [8];
    logic [DW-1:0] regs_d [8];
    logic [DW-1:0] opr_q, opr_d;
    logic [DW-1:0] ops_q, ops_d;
    logic [2:0]    flags_q, flags_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [AW-1:0] mem_addr_q, mem_addr_d;
    logic [DW-1:0] mem_wdata_q, mem_wdata_d;
    logic          halted_q, halted_d;

    logic [3:0]    op;
    logic [2:0]    w_idx, r_idx, s_idx;
    logic [DW-1:0] alu_res;
    logic          alu_c, alu_n, alu_z;
    logic          unused_ir_bits;

    assign op             = ir_q[OP_LSB +: 4];
    assign w_idx          = ir_q[W_LSB +: 3];
    assign r_idx          = ir_q[R_LSB +: 3];
    assign s_idx          = ir_q[S_LSB +: 3];
    assign unused_ir_bits = ^ir_q[11:9];

    alu_cnz #(.DW(DW)) u_alu (
        .op     (op),
        .r      (opr_q),
        .s      (ops_q),
        .result (alu_res),
        .c      (alu_c),
        .n      (alu_n),
        .z      (alu_z)
    );

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        regs_d      = regs_q;
        opr_d       = opr_q;
        ops_d       = ops_q;
        flags_d     = flags_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        halted_d    = halted_q;
        case (state_q)
            ST_FETCH: begin
                // Request is normally raised on entry; this arm covers the
                // first fetch after reset, when nothing has raised it yet.
                if (!mem_req_q) begin
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = pc_q;
                end else if (mem_ack) begin
                    ir_d      = mem_rdata[15:0];
                    pc_d      = pc_q + AW'(1);
                    mem_req_d = 1'b0;
                    state_d   = ST_DECODE;
                end
            end
            ST_DECODE: begin
                opr_d   = regs_q[r_idx];
                ops_d   = regs_q[s_idx];
                state_d = ST_EXEC;
            end
            ST_EXEC: begin
                state_d    = ST_FETCH;
                mem_req_d  = 1'b1;
                mem_we_d   = 1'b0;
                mem_addr_d = pc_q;
                case (op)
                    OP_NOP: ;
                    OP_JMP: begin
                        pc_d       = opr_q[AW-1:0];
                        mem_addr_d = opr_q[AW-1:0];
                    end
                    OP_LD, OP_ST: begin
                        state_d     = ST_MEM;
                        mem_we_d    = (op == OP_ST);
                        mem_addr_d  = opr_q[AW-1:0];
                        mem_wdata_d = ops_q;
                    end
                    OP_HALT: begin
                        state_d   = ST_HALT;
                        mem_req_d = 1'b0;
                        halted_d  = 1'b1;
                    end
                    default: begin
                        regs_d[w_idx] = alu_res;
                        if (sets_flags(op)) flags_d = {alu_c, alu_n, alu_z};
                    end
                endcase
            end
            ST_MEM: begin
                if (mem_ack) begin
                    if (!mem_we_q) regs_d[w_idx] = mem_rdata;
                    state_d    = ST_FETCH;
                    mem_req_d  = 1'b1;
                    mem_we_d   = 1'b0;
                    mem_addr_d = pc_q;
                end
            end
            ST_HALT: ;
            default: state_d = ST_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_FETCH;
            pc_q        <= RST_PC;
            ir_q        <= '0;
            for (int i = 0; i < 8; i++) regs_q[i] <= '0;
            opr_q       <= '0;
            ops_q       <= '0;
            flags_q     <= '0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            halted_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            regs_q      <= regs_d;
            opr_q       <= opr_d;
            ops_q       <= ops_d;
            flags_q     <= flags_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            halted_q    <= halted_d;
        end
    end

    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign pc_out    = pc_q;
    assign flags     = flags_q;
    assign halted    = halted_q;

endmodule
